// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_ctrl
//  Purpose  : Sequencer for an iterative AES-128 decryption datapath.
//             Drives key expansion, the initial AddRoundKey, nine main
//             inverse rounds (InvShiftRows, InvSubBytes, AddRoundKey and
//             InvMixColumns one word at a time) and the final inverse round.
//  Ports    : CLK, RESET (sync, active-high), AES_START (level request)
//             AES_DONE, BUSY            - status
//             LD_MSG, KEY_EXP_EN,
//             INV_SHIFT_EN, INV_SUB_EN,
//             ADD_KEY_EN, INV_MIX_EN    - datapath step enables
//             MIX_WORD[1:0]             - column index for InvMixColumns
//             Round[3:0]                - round-key select (10 .. 0)
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int KEY_EXP_CYCLES = 10   // 1..255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    output logic       AES_DONE,
    output logic       BUSY,
    output logic       LD_MSG,
    output logic       KEY_EXP_EN,
    output logic       INV_SHIFT_EN,
    output logic       INV_SUB_EN,
    output logic       ADD_KEY_EN,
    output logic       INV_MIX_EN,
    output logic [1:0] MIX_WORD,
    output logic [3:0] Round
);

    localparam logic [3:0] c_IDLE        = 4'd0;
    localparam logic [3:0] c_KEY_EXP     = 4'd1;
    localparam logic [3:0] c_ADDKEY_INIT = 4'd2;
    localparam logic [3:0] c_R_SHIFT     = 4'd3;
    localparam logic [3:0] c_R_SUB       = 4'd4;
    localparam logic [3:0] c_R_ADDKEY    = 4'd5;
    localparam logic [3:0] c_R_MIX       = 4'd6;
    localparam logic [3:0] c_F_SHIFT     = 4'd7;
    localparam logic [3:0] c_F_SUB       = 4'd8;
    localparam logic [3:0] c_F_ADDKEY    = 4'd9;
    localparam logic [3:0] c_DONE        = 4'd10;

    localparam logic [7:0] c_KEY_EXP_LOAD = 8'(KEY_EXP_CYCLES - 1);
    localparam logic [3:0] c_ROUND_INIT   = 4'd10;
    localparam logic [3:0] c_ROUND_FIRST  = 4'd9;
    localparam logic [1:0] c_LAST_WORD    = 2'd3;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_kexp_cnt;
    logic [3:0] r_round;
    logic [1:0] r_mix_word;
    logic       r_done;
    logic       r_busy;
    logic       r_ld_msg;
    logic       r_key_exp_en;
    logic       r_shift_en;
    logic       r_sub_en;
    logic       r_add_key_en;
    logic       r_mix_en;
    logic       w_busy_state;

    assign w_busy_state = (r_state != c_IDLE) && (r_state != c_DONE);

    // Next-state decode; dropping AES_START anywhere in the busy part of
    // the sequence aborts straight back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:        if (AES_START) w_next = c_KEY_EXP;
            c_KEY_EXP:     if (r_kexp_cnt == 8'd0) w_next = c_ADDKEY_INIT;
            c_ADDKEY_INIT: w_next = c_R_SHIFT;
            c_R_SHIFT:     w_next = c_R_SUB;
            c_R_SUB:       w_next = c_R_ADDKEY;
            c_R_ADDKEY:    w_next = c_R_MIX;
            c_R_MIX: begin
                // Round 1 is the last main round: after its decrement the
                // key select reaches 0, which belongs to the final round.
                if (r_mix_word == c_LAST_WORD)
                    w_next = (r_round <= 4'd1) ? c_F_SHIFT : c_R_SHIFT;
            end
            c_F_SHIFT:     w_next = c_F_SUB;
            c_F_SUB:       w_next = c_F_ADDKEY;
            c_F_ADDKEY:    w_next = c_DONE;
            c_DONE:        if (!AES_START) w_next = c_IDLE;
            default:       w_next = c_IDLE;
        endcase
        if (w_busy_state && !AES_START)
            w_next = c_IDLE;
    end

    // State, counters and registered outputs. Output flops are loaded from
    // the decode of the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= c_IDLE;
            r_kexp_cnt   <= 8'd0;
            r_round      <= c_ROUND_INIT;
            r_mix_word   <= 2'd0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_ld_msg     <= 1'b0;
            r_key_exp_en <= 1'b0;
            r_shift_en   <= 1'b0;
            r_sub_en     <= 1'b0;
            r_add_key_en <= 1'b0;
            r_mix_en     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == c_IDLE && w_next == c_KEY_EXP)
                r_kexp_cnt <= c_KEY_EXP_LOAD;
            else if (r_state == c_KEY_EXP && w_next == c_KEY_EXP)
                r_kexp_cnt <= r_kexp_cnt - 8'd1;
            else
                r_kexp_cnt <= 8'd0;

            if (w_next == c_IDLE)
                r_round <= c_ROUND_INIT;
            else if (r_state == c_ADDKEY_INIT)
                r_round <= c_ROUND_FIRST;
            else if (r_state == c_R_MIX && r_mix_word == c_LAST_WORD && r_round != 4'd0)
                r_round <= r_round - 4'd1;

            // Word index advances only while staying in R_MIX; it is 0 on
            // entry to R_MIX and everywhere else.
            if (r_state == c_R_MIX && w_next == c_R_MIX)
                r_mix_word <= r_mix_word + 2'd1;
            else
                r_mix_word <= 2'd0;

            r_done       <= (w_next == c_DONE);
            r_busy       <= (w_next != c_IDLE) && (w_next != c_DONE);
            r_ld_msg     <= (r_state == c_IDLE) && (w_next == c_KEY_EXP);
            r_key_exp_en <= (w_next == c_KEY_EXP);
            r_shift_en   <= (w_next == c_R_SHIFT) || (w_next == c_F_SHIFT);
            r_sub_en     <= (w_next == c_R_SUB) || (w_next == c_F_SUB);
            r_add_key_en <= (w_next == c_ADDKEY_INIT) || (w_next == c_R_ADDKEY)
                            || (w_next == c_F_ADDKEY);
            r_mix_en     <= (w_next == c_R_MIX);
        end
    end

    assign AES_DONE     = r_done;
    assign BUSY         = r_busy;
    assign LD_MSG       = r_ld_msg;
    assign KEY_EXP_EN   = r_key_exp_en;
    assign INV_SHIFT_EN = r_shift_en;
    assign INV_SUB_EN   = r_sub_en;
    assign ADD_KEY_EN   = r_add_key_en;
    assign INV_MIX_EN   = r_mix_en;
    assign MIX_WORD     = r_mix_word;
    assign Round        = r_round;

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter: KEY_EXP_CYCLES, 10, number of cycles KEY_EXP_EN is held high (legal range 1..255).
REQ-002 SHALL have port: CLK  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port: RESET  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: AES_START  input  1  level request from the Avalon start register; must stay high for the whole operation.
REQ-005 SHALL have port: AES_DONE  output  1  operation complete; held while AES_START stays high.
REQ-006 SHALL have port: BUSY  output  1  high in every state except IDLE and DONE.
REQ-007 SHALL have port: LD_MSG  output  1  load the ciphertext into the state register.
REQ-008 SHALL have port: KEY_EXP_EN  output  1  key-expansion enable.
REQ-009 SHALL have port: INV_SHIFT_EN  output  1  apply InvShiftRows.
REQ-010 SHALL have port: INV_SUB_EN  output  1  apply InvSubBytes.
REQ-011 SHALL have port: ADD_KEY_EN  output  1  apply AddRoundKey.
REQ-012 SHALL have port: INV_MIX_EN  output  1  apply InvMixColumns to one word.
REQ-013 SHALL have port: MIX_WORD  output  2  word index (0..3) for INV_MIX_EN.
REQ-014 SHALL have port: Round  output  4  round-key select for the round-key demux: 10 at the initial AddRoundKey, 9..1 in the main rounds, 0 in the final round.

Function
REQ-015 SHALL implement these states: IDLE, KEY_EXP, ADDKEY_INIT, R_SHIFT, R_SUB, R_ADDKEY, R_MIX, F_SHIFT, F_SUB, F_ADDKEY, DONE.
REQ-016 SHALL go from IDLE to KEY_EXP when AES_START is sampled high; otherwise SHALL stay in IDLE.
REQ-017 SHALL stay in KEY_EXP for exactly KEY_EXP_CYCLES cycles, counted by an 8-bit down-counter, then go to ADDKEY_INIT.
REQ-018 SHALL assert KEY_EXP_EN throughout KEY_EXP, and SHALL assert LD_MSG only in the first KEY_EXP cycle.
REQ-019 SHALL spend one cycle in ADDKEY_INIT with ADD_KEY_EN=1 and Round=10, then go to R_SHIFT with Round=9.
REQ-020 SHALL run each main round as R_SHIFT, then R_SUB, then R_ADDKEY, one cycle each, then R_MIX for 4 cycles with MIX_WORD=0,1,2,3.
REQ-021 SHALL, at the end of the R_MIX cycle with MIX_WORD=3, decrement Round and go to R_SHIFT if the new Round is nonzero, or to F_SHIFT if it is 0.
REQ-022 SHALL run the final round as F_SHIFT, then F_SUB, then F_ADDKEY, one cycle each, with Round=0 and no InvMixColumns, then go to DONE.
REQ-023 SHALL assert in each state exactly the enable named by that state (R_ and F_ states alike), and all other enables SHALL be 0.
REQ-024 SHALL hold all enables at 0 in IDLE and DONE.
REQ-025 SHALL hold MIX_WORD at 0 outside R_MIX.
REQ-026 SHALL never wrap Round below 0 and SHALL never set it above 10.
REQ-027 SHALL have this latency for KEY_EXP_CYCLES=10, with AES_START sampled at edge 0: KEY_EXP in cycles 1-10, ADDKEY_INIT in cycle 11, main rounds in cycles 12-74, final round in cycles 75-77, AES_DONE=1 from cycle 78.
REQ-028 SHALL, in DONE, hold AES_DONE=1 while AES_START=1, and go to IDLE on the cycle after AES_START is sampled low.
REQ-029 SHALL abort to IDLE on the next edge if AES_START is sampled low in any BUSY state; AES_DONE SHALL stay 0 and Round SHALL return to 10.
REQ-030 SHALL, in IDLE with AES_START held high after an abort or after DONE->IDLE, start a new operation (REQ-016).

Reset
REQ-031 SHALL, when RESET is high at a rising edge, enter IDLE regardless of state or AES_START, with Round=10, MIX_WORD=0, all enables 0, AES_DONE=0, BUSY=0 and the KEY_EXP counter cleared.
REQ-032 SHALL take RESET over AES_START when both are high, and SHALL honour AES_START from the first edge after RESET falls.

Verification
REQ-033 Nominal: RESET 2 cycles, then AES_START=1 held -> LD_MSG=1 only in cycle 1; KEY_EXP_EN high cycles 1-10; ADD_KEY_EN with Round=10 in cycle 11; AES_DONE=1 at cycle 78; exactly 9 R_MIX groups; 11 ADD_KEY_EN pulses with Round 10,9,...,0.
REQ-034 Round trace: log Round on each ADD_KEY_EN pulse -> strictly decreasing 10..0 with no repeats; MIX_WORD sequence 0,1,2,3 in each of the 9 main rounds; no INV_MIX_EN in cycles 75-77.
REQ-035 Abort: drop AES_START in cycle 40 (main round) -> IDLE at cycle 41; BUSY=0, all enables 0, Round=10, AES_DONE never asserted.
REQ-036 Reset mid-operation: RESET=1 in cycle 20 with AES_START high -> IDLE with reset values next cycle; RESET low with AES_START still high -> new KEY_EXP starts one cycle later.
REQ-037 Done handshake: hold AES_START 5 cycles past DONE -> AES_DONE stays 1; drop AES_START -> AES_DONE=0 next cycle; raise it again -> KEY_EXP follows.
REQ-038 Parameter: KEY_EXP_CYCLES=1 -> KEY_EXP_EN high in 1 cycle only; AES_DONE=1 at cycle 69.
